// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter / AXI4 master bridge.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP
  } arb_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_LSU   = 1'b1;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant selection for the two requesters. ARB_ROUND_ROBIN_EN selects round-robin;
// otherwise fixed priority with the LSU (requester 1) always winning.
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic       aclk,
  input  logic       aresetn,
  input  logic [1:0] req_valid,
  input  logic       accept,
  output logic       grant
);

`ifdef ARB_ROUND_ROBIN_EN
  // prio_q names the requester that wins the next tie
  logic prio_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      prio_q <= REQ_FETCH;
    end else if (accept) begin
      prio_q <= ~grant;
    end
  end

  always_comb begin
    if (req_valid == 2'b11) begin
      grant = prio_q;
    end else begin
      grant = req_valid[1];
    end
  end
`else
  logic unused_grant_in;
  assign unused_grant_in = aclk ^ aresetn ^ accept ^ req_valid[0];
  assign grant = req_valid[1] ? REQ_LSU : REQ_FETCH;
`endif

endmodule

// File: rtl/mem_axi_arbiter.sv
// Two-requester arbiter and single-outstanding AXI4 master bridge (single-beat transfers).
// Grant policy selected by ARB_ROUND_ROBIN_EN (see mem_arb_grant).
module mem_axi_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic                   aclk,
  input  logic                   aresetn,

  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0]             req_wen,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][DATA_W-1:0] req_wdata,
  input  logic [1:0][STRB_W-1:0] req_wstrb,
  output logic [1:0]             resp_valid,
  output logic [DATA_W-1:0]      resp_rdata,
  output logic                   resp_err,

  output logic                   arvalid,
  input  logic                   arready,
  output logic [ADDR_W-1:0]      araddr,
  output logic [3:0]             arid,
  output logic [7:0]             arlen,
  output logic [2:0]             arsize,
  output logic [1:0]             arburst,

  input  logic                   rvalid,
  output logic                   rready,
  input  logic [DATA_W-1:0]      rdata,
  input  logic [1:0]             rresp,
  input  logic                   rlast,
  input  logic [3:0]             rid,

  output logic                   awvalid,
  input  logic                   awready,
  output logic [ADDR_W-1:0]      awaddr,
  output logic [3:0]             awid,
  output logic [7:0]             awlen,
  output logic [2:0]             awsize,
  output logic [1:0]             awburst,

  output logic                   wvalid,
  input  logic                   wready,
  output logic [DATA_W-1:0]      wdata,
  output logic [STRB_W-1:0]      wstrb,
  output logic                   wlast,

  input  logic                   bvalid,
  output logic                   bready,
  input  logic [1:0]             bresp,
  input  logic [3:0]             bid
);

  localparam logic [2:0] AXI_SIZE = 3'($clog2(STRB_W));

  arb_state_e        state_q, state_d;
  logic              grant, grant_q;
  logic              accept;
  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              aw_done, w_done;
  logic              aw_hs, w_hs;
  logic [1:0]        resp_valid_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              resp_err_q;

  // IDs are not used for routing; the latched grant is authoritative
  logic unused_ids;
  assign unused_ids = ^{rid, bid};

  // No accept while the previous completion pulse is out: earliest re-grant is the cycle after
  assign accept = (state_q == IDLE) && (resp_valid_q == 2'b00) && (|req_valid);
  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;

  mem_arb_grant u_grant (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .req_valid (req_valid),
    .accept    (accept),
    .grant     (grant)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = req_wen[grant] ? WR_REQ : RD_ADDR;
      RD_ADDR: if (arready) state_d = RD_DATA;
      RD_DATA: if (rvalid && rlast) state_d = IDLE;
      WR_REQ:  if ((aw_done || aw_hs) && (w_done || w_hs)) state_d = WR_RESP;
      WR_RESP: if (bvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    case (state_q)
      IDLE:    if (accept && aresetn) req_ready[grant] = 1'b1;
      RD_ADDR: arvalid = 1'b1;
      RD_DATA: rready = 1'b1;
      WR_REQ: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
      end
      WR_RESP: bready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      grant_q      <= REQ_FETCH;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      resp_valid_q <= 2'b00;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= 2'b00;
      if (accept) begin
        grant_q <= grant;
        wen_q   <= req_wen[grant];
        addr_q  <= req_addr[grant];
        wdata_q <= req_wdata[grant];
        wstrb_q <= req_wstrb[grant];
      end
      if (state_q == WR_REQ && state_d == WR_RESP) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      // A beat without rlast is a slave protocol error and is dropped
      if (state_q == RD_DATA && rvalid && rlast) begin
        resp_valid_q[grant_q] <= 1'b1;
        resp_rdata_q          <= rdata;
        resp_err_q            <= (rresp != AXI_RESP_OKAY);
      end
      if (state_q == WR_RESP && bvalid) begin
        resp_valid_q[grant_q] <= 1'b1;
        resp_err_q            <= (bresp != AXI_RESP_OKAY);
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  assign araddr  = addr_q;
  assign arid    = {3'b000, grant_q};
  assign arlen   = 8'd0;
  assign arsize  = AXI_SIZE;
  assign arburst = AXI_BURST_INCR;

  assign awaddr  = addr_q;
  assign awid    = {3'b000, grant_q};
  assign awlen   = 8'd0;
  assign awsize  = AXI_SIZE;
  assign awburst = AXI_BURST_INCR;

  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;

endmodule

// File: tb/tb_mem_axi_arbiter.sv
// Directed bench for mem_axi_arbiter; the bench plays the AXI slave cycle by cycle.
// Contention expectations follow ARB_ROUND_ROBIN_EN.
module tb_mem_axi_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int STRB_W = 8;

  logic                   aclk = 1'b0;
  logic                   aresetn;
  logic [1:0]             req_valid, req_ready, req_wen, resp_valid;
  logic [1:0][ADDR_W-1:0] req_addr;
  logic [1:0][DATA_W-1:0] req_wdata;
  logic [1:0][STRB_W-1:0] req_wstrb;
  logic [DATA_W-1:0]      resp_rdata;
  logic                   resp_err;
  logic                   arvalid, arready, rvalid, rready, rlast;
  logic                   awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [ADDR_W-1:0]      araddr, awaddr;
  logic [3:0]             arid, awid, rid, bid;
  logic [7:0]             arlen, awlen;
  logic [2:0]             arsize, awsize;
  logic [1:0]             arburst, awburst, rresp, bresp;
  logic [DATA_W-1:0]      rdata, wdata;
  logic [STRB_W-1:0]      wstrb;

  int tests  = 0;
  int failed = 0;

`ifdef ARB_ROUND_ROBIN_EN
  logic [2:0] exp_g = 3'b010;
`else
  logic [2:0] exp_g = 3'b111;
`endif

  always #5 aclk = ~aclk;

  mem_axi_arbiter dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rid(rid),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge aclk);
    #1;
  endtask

  task automatic sample();
    @(negedge aclk);
  endtask

  initial begin
    aresetn   = 1'b0;
    req_valid = '0; req_wen = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    arready = 0; rvalid = 0; rdata = '0; rresp = 0; rlast = 0; rid = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = '0;

    // reset state
    sample();
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_resp_valid", resp_valid, 2'b00);
    check("rst_resp_rdata", resp_rdata, 64'h0);
    check("rst_resp_err", resp_err, 1'b0);
    check("rst_valids", {arvalid, awvalid, wvalid}, 3'b000);
    check("rst_readies", {rready, bready}, 2'b00);
    next_cycle();
    aresetn = 1'b1;
    sample();

    // single read, requester 0
    next_cycle();
    req_valid = 2'b01; req_wen = 2'b00; req_addr[0] = 32'h8000_0000;
    sample();
    check("rd_accept", req_ready, 2'b01);
    check("rd_c0_arvalid", arvalid, 1'b0);
    next_cycle();
    req_valid = 2'b00; arready = 1;
    sample();
    check("rd_arvalid", arvalid, 1'b1);
    check("rd_araddr", araddr, 32'h8000_0000);
    check("rd_arid", arid, 4'd0);
    check("rd_arconst", {arlen, arsize, arburst}, {8'd0, 3'd3, 2'b01});
    check("rd_c1_ready", req_ready, 2'b00);
    next_cycle();
    arready = 0; rvalid = 1; rlast = 1; rresp = 2'b00; rdata = 64'h1122_3344_5566_7788;
    sample();
    check("rd_rready", rready, 1'b1);
    check("rd_c2_resp", resp_valid, 2'b00);
    next_cycle();
    rvalid = 0; rlast = 0; rdata = '0;
    req_valid = 2'b10; req_wen = 2'b10; req_addr[1] = 32'h8000_0010;
    req_wdata[1] = 64'h0000_0000_DEAD_BEEF; req_wstrb[1] = 8'h0F;
    sample();
    check("rd_resp_valid", resp_valid, 2'b01);
    check("rd_resp_rdata", resp_rdata, 64'h1122_3344_5566_7788);
    check("rd_resp_err", resp_err, 1'b0);
    check("rd_no_regrant", req_ready, 2'b00);

    // single write, requester 1 (accepted the cycle after the read response)
    next_cycle();
    sample();
    check("wr_accept", req_ready, 2'b10);
    next_cycle();
    req_valid = 2'b00; awready = 1; wready = 1;
    sample();
    check("wr_aw_w_valid", {awvalid, wvalid}, 2'b11);
    check("wr_awaddr", awaddr, 32'h8000_0010);
    check("wr_awid", awid, 4'd1);
    check("wr_wdata", wdata, 64'h0000_0000_DEAD_BEEF);
    check("wr_wstrb", wstrb, 8'h0F);
    check("wr_wlast", wlast, 1'b1);
    check("wr_awconst", {awlen, awsize, awburst}, {8'd0, 3'd3, 2'b01});
    next_cycle();
    awready = 0; wready = 0; bvalid = 1; bresp = 2'b00;
    sample();
    check("wr_bready", bready, 1'b1);
    check("wr_aw_w_dropped", {awvalid, wvalid}, 2'b00);
    next_cycle();
    bvalid = 0;
    sample();
    check("wr_resp_valid", resp_valid, 2'b10);
    check("wr_resp_err", resp_err, 1'b0);

    // contention: both requesters, three rounds
    for (int r = 0; r < 3; r++) begin
      next_cycle();
      if (r == 0) begin
        req_valid = 2'b11; req_wen = 2'b00;
        req_addr[0] = 32'h8000_0100; req_addr[1] = 32'h8000_0200;
      end
      sample();
      check($sformatf("cont%0d_grant", r), req_ready, exp_g[r] ? 2'b10 : 2'b01);
      next_cycle();
      req_valid[exp_g[r]] = 1'b0; arready = 1;
      sample();
      check($sformatf("cont%0d_arid", r), arid, {3'b000, exp_g[r]});
      check($sformatf("cont%0d_araddr", r), araddr, exp_g[r] ? 32'h8000_0200 : 32'h8000_0100);
      next_cycle();
      arready = 0; rvalid = 1; rlast = 1; rresp = 0; rdata = 64'h100 + 64'(r);
      sample();
      next_cycle();
      rvalid = 0; rlast = 0;
      if (r < 2) req_valid[exp_g[r]] = 1'b1;
      else req_valid = 2'b00;
      sample();
      check($sformatf("cont%0d_resp", r), resp_valid, exp_g[r] ? 2'b10 : 2'b01);
      check($sformatf("cont%0d_rdata", r), resp_rdata, 64'h100 + 64'(r));
      check($sformatf("cont%0d_no_regrant", r), req_ready, 2'b00);
    end

    // channel skew: wready stalled three cycles after awready
    next_cycle();
    req_valid = 2'b01; req_wen = 2'b01; req_addr[0] = 32'h8000_0020;
    req_wdata[0] = 64'h0123_4567_89AB_CDEF; req_wstrb[0] = 8'hFF;
    sample();
    check("skew_accept", req_ready, 2'b01);
    next_cycle();
    req_valid = 2'b00; awready = 1; wready = 0;
    sample();
    check("skew_c1_valids", {awvalid, wvalid}, 2'b11);
    check("skew_awid", awid, 4'd0);
    for (int c = 2; c <= 3; c++) begin
      next_cycle();
      awready = 0;
      sample();
      check($sformatf("skew_c%0d_valids", c), {awvalid, wvalid}, 2'b01);
      check($sformatf("skew_c%0d_bready", c), bready, 1'b0);
    end
    next_cycle();
    wready = 1;
    sample();
    check("skew_c4_valids", {awvalid, wvalid}, 2'b01);
    check("skew_c4_wdata", wdata, 64'h0123_4567_89AB_CDEF);
    check("skew_c4_bready", bready, 1'b0);
    next_cycle();
    wready = 0; bvalid = 1; bresp = 2'b00;
    sample();
    check("skew_c5_valids", {awvalid, wvalid}, 2'b00);
    check("skew_c5_bready", bready, 1'b1);
    next_cycle();
    bvalid = 0;
    sample();
    check("skew_resp", resp_valid, 2'b01);

    // arready stall, stray non-last beat, then SLVERR
    next_cycle();
    req_valid = 2'b01; req_wen = 2'b00; req_addr[0] = 32'h8000_0040;
    sample();
    check("err_accept", req_ready, 2'b01);
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      req_valid = 2'b00;
      sample();
      check($sformatf("err_stall%0d_arvalid", c), arvalid, 1'b1);
    end
    next_cycle();
    arready = 1;
    sample();
    check("err_c6_arvalid", arvalid, 1'b1);
    next_cycle();
    arready = 0; rvalid = 1; rlast = 0; rresp = 2'b00; rdata = 64'hAAAA_AAAA_AAAA_AAAA;
    sample();
    check("err_nolast_rready", rready, 1'b1);
    next_cycle();
    rlast = 1; rresp = 2'b10; rdata = 64'h5555_0000_5555_0000;
    sample();
    check("err_nolast_no_resp", resp_valid, 2'b00);
    check("err_c8_rready", rready, 1'b1);
    next_cycle();
    rvalid = 0; rlast = 0; rresp = 0;
    sample();
    check("err_resp_valid", resp_valid, 2'b01);
    check("err_resp_err", resp_err, 1'b1);
    check("err_resp_rdata", resp_rdata, 64'h5555_0000_5555_0000);

    // reset asserted while waiting in RD_DATA
    next_cycle();
    req_valid = 2'b10; req_wen = 2'b00; req_addr[1] = 32'h8000_0080;
    sample();
    check("mrst_accept", req_ready, 2'b10);
    next_cycle();
    req_valid = 2'b00; arready = 1;
    sample();
    next_cycle();
    arready = 0;
    sample();
    check("mrst_rready_before", rready, 1'b1);
    #2;
    aresetn = 1'b0;
    #1;
    check("mrst_rready", rready, 1'b0);
    check("mrst_resp_err", resp_err, 1'b0);
    check("mrst_resp_rdata", resp_rdata, 64'h0);
    check("mrst_valids", {arvalid, awvalid, wvalid, bready}, 4'b0000);
    next_cycle();
    rvalid = 1; rlast = 1; rdata = 64'h7777_7777_7777_7777;
    sample();
    check("mrst_hold_resp", resp_valid, 2'b00);
    next_cycle();
    aresetn = 1'b1; rvalid = 0; rlast = 0;
    sample();
    check("mrst_after_resp", resp_valid, 2'b00);
    next_cycle();
    sample();
    check("mrst_idle_resp", resp_valid, 2'b00);
    check("mrst_idle_rready", rready, 1'b0);

    // normal read after the aborted one
    next_cycle();
    req_valid = 2'b01; req_wen = 2'b00; req_addr[0] = 32'h8000_00C0;
    sample();
    check("post_accept", req_ready, 2'b01);
    next_cycle();
    req_valid = 2'b00; arready = 1;
    sample();
    check("post_araddr", araddr, 32'h8000_00C0);
    next_cycle();
    arready = 0; rvalid = 1; rlast = 1; rresp = 0; rdata = 64'hCAFE_F00D_0000_0001;
    sample();
    next_cycle();
    rvalid = 0; rlast = 0;
    sample();
    check("post_resp_valid", resp_valid, 2'b01);
    check("post_resp_rdata", resp_rdata, 64'hCAFE_F00D_0000_0001);
    check("post_resp_err", resp_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
